// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit, imported by the MDU,
// control unit and hazard detection unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Applies two's-complement sign correction to the magnitude results of the
// iterative multiply/divide datapath.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic             neg_a_i,
  input  logic             neg_b_i,
  input  logic [WIDTH-1:0] raw_hi_i,
  input  logic [WIDTH-1:0] raw_lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign prod     = {raw_hi_i, raw_lo_i};
  assign prod_neg = -prod;

  always_comb begin
    hi_o = raw_hi_i;
    lo_o = raw_lo_i;
    if (is_div_i) begin
      // Quotient follows the sign product, remainder follows the dividend.
      if (neg_a_i ^ neg_b_i) lo_o = -raw_lo_i;
      if (neg_a_i)           hi_o = -raw_hi_i;
    end else if (neg_a_i ^ neg_b_i) begin
      {hi_o, lo_o} = prod_neg;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step
// per cycle on magnitudes, sign correction in a final FIX cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_e         state_q, state_d;
  logic               is_div_q;
  logic               neg_a_q, neg_b_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dbz_q;

  logic               accept;
  logic               sgn_op;
  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   raw_hi;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign accept   = (state_q == MDU_IDLE) && start && !flush;
  assign sgn_op   = mdu_is_signed(op);
  assign neg_a_in = sgn_op && op_a[WIDTH-1];
  assign neg_b_in = sgn_op && op_b[WIDTH-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign a_abs    = neg_a_in ? -op_a : op_a;
  assign b_abs    = neg_b_in ? -op_b : op_b;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  // The true difference is below 2^WIDTH whenever it is used, so WIDTH bits suffice.
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;

  assign raw_hi = is_div_q ? rem_q : acc_q[2*WIDTH-1:WIDTH];

  mdu_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .is_div_i(is_div_q),
    .neg_a_i (neg_a_q),
    .neg_b_i (neg_b_q),
    .raw_hi_i(raw_hi),
    .raw_lo_i(acc_q[WIDTH-1:0]),
    .hi_o    (fix_hi),
    .lo_o    (fix_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= MDU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (start && !flush) state_d = MDU_RUN;
      MDU_RUN: begin
        if (flush)              state_d = MDU_IDLE;
        else if (cnt_q == '0)   state_d = MDU_FIX;
      end
      MDU_FIX:  state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (accept) begin
            is_div_q <= mdu_is_div(op);
            neg_a_q  <= neg_a_in;
            neg_b_q  <= neg_b_in;
            rem_q    <= '0;
            cnt_q    <= CNT_W'(WIDTH - 1);
            busy_q   <= 1'b1;
            // Low half of the accumulator holds the multiplier or the dividend.
            if (mdu_is_div(op)) begin
              b_q   <= b_abs;
              acc_q <= {{WIDTH{1'b0}}, a_abs};
            end else begin
              b_q   <= a_abs;
              acc_q <= {{WIDTH{1'b0}}, b_abs};
            end
          end
        end
        MDU_RUN: begin
          if (flush) begin
            busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (is_div_q) begin
              rem_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
              acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
            end else begin
              acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
            end
          end
        end
        MDU_FIX: begin
          busy_q <= 1'b0;
          if (!flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            dbz_q  <= is_div_q && (b_q == '0);
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO come from a behavioural
// arithmetic model and are compared whenever done pulses.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [1:0]   op;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    longint       sa, sb, q, r;
    logic [63:0]  p;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.dbz = o[1] && (b == '0);
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); {e.hi, e.lo} = p; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = p; end
      2'b10: begin
        if (b == '0) begin
          e.hi = a;
          e.lo = a[W-1] ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
          q = sa / sb;
          r = sa % sb;
          e.lo = W'(q);
          e.hi = W'(r);
        end
      end
      default: begin
        if (b == '0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("sb_hi", hi, mon_e.hi);
        check_eq("sb_lo", lo, mon_e.lo);
        check_eq("sb_dbz", div_by_zero, mon_e.dbz);
      end
    end else if (div_by_zero === 1'b1) begin
      check_eq("dbz_without_done", 1, 0);
    end
  end

  // Called at a negedge; returns at the negedge where done is high.
  // poke >= 0 pulses a stray start at that cycle of the operation.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int poke);
    int   n;
    logic busy_ok;
    sb_q.push_back(model(o, a, b));
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    n = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (n == poke) begin
        start = 1'b1; op = ~o; op_a = 32'h0000_0003; op_b = 32'h0000_0005;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_eq("latency", n, 33);
    check_eq("busy_during_op", busy_ok, 1);
    check_eq("busy_in_done_cycle", busy, 0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check_eq(tag, pulses, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    op = 2'b00; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check_eq("t1_hi", hi, 32'hFFFF_FFFE);
    check_eq("t1_lo", lo, 32'h0000_0001);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1);
    check_eq("t2_mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("t2_mult_lo", lo, 32'hFFFF_FFEB);
    do_op(2'b11, 32'd7, 32'd2, -1);
    check_eq("t2_divu_lo", lo, 32'd3);
    check_eq("t2_divu_hi", hi, 32'd1);

    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    check_eq("t3_div_lo", lo, 32'hFFFF_FFFD);
    check_eq("t3_div_hi", hi, 32'hFFFF_FFFF);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check_eq("t3_ovf_lo", lo, 32'h8000_0000);
    check_eq("t3_ovf_hi", hi, 32'h0000_0000);

    do_op(2'b11, 32'd5, 32'd0, -1);
    check_eq("t4_dz_lo", lo, 32'hFFFF_FFFF);
    check_eq("t4_dz_hi", hi, 32'd5);
    check_eq("t4_dz_flag", div_by_zero, 1);
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, -1);
    check_eq("t4_sdz_flag", div_by_zero, 1);

    // Preload hi/lo = 0x11/0x22 through 0x451 / 0x20.
    do_op(2'b11, 32'h0000_0451, 32'h0000_0020, -1);
    check_eq("t5_pre_hi", hi, 32'h11);
    check_eq("t5_pre_lo", lo, 32'h22);
    @(negedge clk);
    start = 1'b1; op = 2'b01; op_a = 32'hFFFF_FFFF; op_b = 32'h0001_2345;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("t5_flush_busy", busy, 0);
    check_eq("t5_flush_hi", hi, 32'h11);
    check_eq("t5_flush_lo", lo, 32'h22);
    expect_quiet("t5_flush_no_done", 40);
    check_eq("t5_after_hi", hi, 32'h11);
    check_eq("t5_after_lo", lo, 32'h22);

    do_op(2'b01, 32'h0000_1234, 32'h0000_5678, 5);
    check_eq("t5_poke_lo", lo, 32'h0626_0060);
    expect_quiet("t5_poke_no_extra_done", 40);

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? W'($urandom_range(1, 255)) : $urandom;
      if (i == 5) rb = 32'hFFFF_FFFF;
      do_op(ro, ra, rb, -1);
    end

    @(negedge clk);
    start = 1'b1; op = 2'b10; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("t6_rst_hi", hi, 0);
    check_eq("t6_rst_lo", lo, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_done", done, 0);
    check_eq("t6_rst_dbz", div_by_zero, 0);
    start = 1'b1; flush = 1'b1; op = 2'b01; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_eq("t6_startflush_busy", busy, 0);
    expect_quiet("t6_startflush_no_done", 40);

    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1);
    check_eq("t6_minsq_hi", hi, 32'h4000_0000);
    check_eq("t6_minsq_lo", lo, 32'h0000_0000);

    repeat (2) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
